alu32_flag_stage: RTL and testbench
===================================

# alu32_flag_stage

Registered write-back stage directly downstream of `alu32`. It accepts one ALU result with its c/n/z/v flags per handshake and evaluates a 4-bit condition code against the architectural NZCV register. If the condition passes, it updates NZCV and forwards the result as taken; if it fails, it forwards the result as suppressed. Output goes through a 2-entry buffer with a valid/ready handshake and no combinational path from `out_ready` to `in_ready`.

## Interface
Parameters:
- `DEPTH`, 2: output buffer entries (power of 2, ≥2)
- `CNT_W`, 16: width of the taken and suppressed statistics counters

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock; all state updates on rising edge
- `reset_n`  in  1  synchronous active-low reset
- `in_valid`  in  1  ALU output valid
- `in_ready`  out  1  stage can accept
- `in_result`  in  32  ALU result
- `in_c`, `in_n`, `in_z`, `in_v`  in  1 each  ALU flags
- `in_cond`  in  4  condition code
- `in_flag_we`  in  1  update NZCV if taken
- `out_valid`  out  1  buffer head valid
- `out_ready`  in  1  consumer accepts
- `out_result`  out  32  buffered result
- `out_taken`  out  1  1 = condition passed
- `nzcv`  out  4  architectural flags {N,Z,C,V}
- `taken_cnt`, `skip_cnt`  out  CNT_W  saturating statistics

## Operation
- Accept: `in_valid && in_ready` at a rising edge.
- Condition evaluation uses the current `nzcv` register value, before this op's update:
  - EQ 0000: Z
  - NE 0001: !Z
  - CS 0010: C
  - CC 0011: !C
  - MI 0100: N
  - PL 0101: !N
  - VS 0110: V
  - VC 0111: !V
  - HI 1000: C&!Z
  - LS 1001: !C|Z
  - GE 1010: N==V
  - LT 1011: N!=V
  - GT 1100: !Z&(N==V)
  - LE 1101: Z|(N!=V)
  - AL 1110: 1
  - NV 1111: 0
- Taken: if `in_flag_we`, `nzcv` ← {in_n,in_z,in_c,in_v}. `taken_cnt`+1. Pushed entry has taken=1.
- Suppressed: `nzcv` unchanged, even if `in_flag_we`=1. `skip_cnt`+1. Entry is still pushed with taken=0 and the result unmodified.
- Counters saturate at all-ones and never wrap.
- Buffer: circular, DEPTH entries, with wr_ptr/rd_ptr and a count register.
  - Pop on `out_valid && out_ready`.
  - `in_ready` = count < DEPTH, derived from registered state only.
  - Full: simultaneous pop does not enable a push that cycle; `in_ready` rises the cycle after the pop.
  - Empty: `out_valid`=0; `out_result`/`out_taken` hold the last-read entry (don't-care).
  - Simultaneous push and pop when not full: count unchanged, both pointers advance, pointers wrap modulo DEPTH.
- Back-to-back ops: op k+1 evaluates its condition against NZCV already updated by op k at the previous edge.

## Timing
- Latency: accepted at edge t → `out_valid`=1 from t (visible in the following cycle) with that entry at the head, provided the buffer was empty.
- `nzcv` update is visible the cycle after accept.
- Throughput: 1 op/cycle while `out_ready`=1.
- Reset (`reset_n`=0 at an edge) forces:
  - `nzcv`=0000, count=0, pointers=0
  - `out_valid`=0, `in_ready`=0 during reset, 1 the first cycle after deassertion
  - counters=0, `out_result`=0, `out_taken`=0
- Reset mid-operation discards all buffered entries. An input presented in the reset cycle is not accepted.
- Inputs are sampled only at the accept edge. They may change freely when not accepted.

## Structure
- Shared package `alu32_pkg`:
  - `COND_EQ`…`COND_NV` localparams
  - NZCV bit indices (N=3, Z=2, C=1, V=0)
  - `ALU_W`=32
- Sub-module `alu32_cond_eval`: combinational, (cond[3:0], nzcv[3:0]) → pass. Separately unit-testable.
- Buffer storage and pointer logic stay inline in the top level.

## Test plan
- Reset then AL with flag_we, result 0xFFFFFFFF, n=1 → `out_taken`=1, `out_result`=0xFFFFFFFF, `nzcv`=1000 next cycle, `taken_cnt`=1.
- NZCV=0100 (Z set):
  - EQ, result 0x5, flag_we=1, flags 0001 → taken, `nzcv`=0001.
  - Then EQ again → suppressed, `nzcv` stays 0001, `skip_cnt`=1.
- GE/LT/GT/LE sweep with NZCV ∈ {0000,1001,1000,0001,0100} → `out_taken` matches the condition table for all 20 combinations.
- Hold `out_ready`=0 and push 3 valid ops (results 0x1, 0x2, 0x3):
  - `in_ready`=0 after 2 accepts; third op held.
  - Release `out_ready` → outputs 0x1, 0x2, 0x3 in order, no loss or duplication.
- Continuous `in_valid`/`out_ready` for 8 ops (0x10..0x17) → one output per cycle, count constant, pointers wrap cleanly.
- Assert `reset_n`=0 with 2 entries buffered and NZCV=1111 → next cycle `out_valid`=0, `nzcv`=0000, counters 0, buffered data never emitted.

Source files
------------

// File: rtl/alu32_pkg.sv
// Shared definitions for the alu32 write-back path: condition codes,
// NZCV bit positions and datapath width.
package alu32_pkg;

   localparam int ALU_W = 32;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int NZCV_N = 3;
   localparam int NZCV_Z = 2;
   localparam int NZCV_C = 1;
   localparam int NZCV_V = 0;

endpackage

// File: rtl/alu32_cond_eval.sv
// Combinational condition-code check of a 4-bit cond against the NZCV flags.
module alu32_cond_eval
   import alu32_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_nzcv,
   output logic       o_pass
);

   logic w_n;
   logic w_z;
   logic w_c;
   logic w_v;

   assign w_n = i_nzcv[NZCV_N];
   assign w_z = i_nzcv[NZCV_Z];
   assign w_c = i_nzcv[NZCV_C];
   assign w_v = i_nzcv[NZCV_V];

   always_comb begin
      o_pass = 1'b0;
      case (i_cond)
         COND_EQ: o_pass = w_z;
         COND_NE: o_pass = !w_z;
         COND_CS: o_pass = w_c;
         COND_CC: o_pass = !w_c;
         COND_MI: o_pass = w_n;
         COND_PL: o_pass = !w_n;
         COND_VS: o_pass = w_v;
         COND_VC: o_pass = !w_v;
         COND_HI: o_pass = w_c && !w_z;
         COND_LS: o_pass = !w_c || w_z;
         COND_GE: o_pass = (w_n == w_v);
         COND_LT: o_pass = (w_n != w_v);
         COND_GT: o_pass = !w_z && (w_n == w_v);
         COND_LE: o_pass = w_z || (w_n != w_v);
         COND_AL: o_pass = 1'b1;
         COND_NV: o_pass = 1'b0;
         default: o_pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu32_flag_stage.sv
// Conditional flag write-back stage: evaluates cond against NZCV, updates the
// flags on taken ops and forwards every result through a small output buffer.
module alu32_flag_stage
   import alu32_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ALU_W-1:0] in_result,
   input  logic             in_c,
   input  logic             in_n,
   input  logic             in_z,
   input  logic             in_v,
   input  logic [3:0]       in_cond,
   input  logic             in_flag_we,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ALU_W-1:0] out_result,
   output logic             out_taken,
   output logic [3:0]       nzcv,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] skip_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   logic [ALU_W-1:0] r_mem_result [DEPTH];
   logic             r_mem_taken  [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic [3:0]       r_nzcv;
   logic [CNT_W-1:0] r_taken_cnt;
   logic [CNT_W-1:0] r_skip_cnt;
   logic             r_rst_done;

   logic w_pass;
   logic w_push;
   logic w_pop;

   alu32_cond_eval u_cond_eval (
      .i_cond (in_cond),
      .i_nzcv (r_nzcv),
      .o_pass (w_pass)
   );

   // r_rst_done keeps in_ready low while reset is held, without a reset_n comb path.
   assign in_ready   = r_rst_done && (r_count < DEPTH_C);
   assign out_valid  = (r_count != '0);
   assign w_push     = in_valid && in_ready;
   assign w_pop      = out_valid && out_ready;
   assign out_result = r_mem_result[r_rd_ptr];
   assign out_taken  = r_mem_taken[r_rd_ptr];
   assign nzcv       = r_nzcv;
   assign taken_cnt  = r_taken_cnt;
   assign skip_cnt   = r_skip_cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rst_done <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_result[i] <= '0;
            r_mem_taken[i]  <= 1'b0;
         end
      end else begin
         r_rst_done <= 1'b1;
         if (w_push) begin
            r_mem_result[r_wr_ptr] <= in_result;
            r_mem_taken[r_wr_ptr]  <= w_pass;
            r_wr_ptr               <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + (PTR_W+1)'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - (PTR_W+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_nzcv      <= 4'b0000;
         r_taken_cnt <= '0;
         r_skip_cnt  <= '0;
      end else if (w_push) begin
         if (w_pass) begin
            if (in_flag_we) begin
               r_nzcv <= {in_n, in_z, in_c, in_v};
            end
            if (r_taken_cnt != '1) begin
               r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            end
         end else if (r_skip_cnt != '1) begin
            r_skip_cnt <= r_skip_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu32_flag_stage.sv
// Directed self-checking bench for alu32_flag_stage with hand-computed expectations.
module tb_alu32_flag_stage;
   import alu32_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic        in_c;
   logic        in_n;
   logic        in_z;
   logic        in_v;
   logic [3:0]  in_cond;
   logic        in_flag_we;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_taken;
   logic [3:0]  nzcv;
   logic [15:0] taken_cnt;
   logic [15:0] skip_cnt;

   int assertCount = 0;
   int failCount   = 0;

   alu32_flag_stage #(.DEPTH(2), .CNT_W(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_c       (in_c),
      .in_n       (in_n),
      .in_z       (in_z),
      .in_v       (in_v),
      .in_cond    (in_cond),
      .in_flag_we (in_flag_we),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_taken  (out_taken),
      .nzcv       (nzcv),
      .taken_cnt  (taken_cnt),
      .skip_cnt   (skip_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one input beat (flags given as {N,Z,C,V}) and advance to just after the edge.
   task automatic applyStimulus(input logic valid, input logic [3:0] cond, input logic we,
                                input logic [31:0] result, input logic [3:0] flags);
      in_valid   = valid;
      in_cond    = cond;
      in_flag_we = we;
      in_result  = result;
      in_n       = flags[3];
      in_z       = flags[2];
      in_c       = flags[1];
      in_v       = flags[0];
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, COND_AL, 1'b0, 32'h0, 4'b0000);
   endtask

   logic [3:0] sweepNzcv [5];
   logic [3:0] sweepExp  [5];
   logic [3:0] sweepCond [4];
   logic [3:0] miscCond  [12];
   logic       miscExp   [12];

   initial begin
      sweepNzcv = '{4'b0000, 4'b1001, 4'b1000, 4'b0001, 4'b0100};
      // Expected pass bits ordered {GE,LT,GT,LE}
      sweepExp  = '{4'b1010, 4'b1010, 4'b0101, 4'b0101, 4'b1001};
      sweepCond = '{COND_GE, COND_LT, COND_GT, COND_LE};
      miscCond  = '{COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL,
                    COND_VS, COND_VC, COND_HI, COND_LS, COND_AL, COND_NV};
      miscExp   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                    1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

      reset_n   = 1'b0;
      out_ready = 1'b1;
      applyStimulus(1'b1, COND_AL, 1'b1, 32'hDEAD_BEEF, 4'b1111);
      applyStimulus(1'b1, COND_AL, 1'b1, 32'hDEAD_BEEF, 4'b1111);
      checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_nzcv", {28'b0, nzcv}, 32'd0);
      checkOutput("rst_taken_cnt", {16'b0, taken_cnt}, 32'd0);
      checkOutput("rst_skip_cnt", {16'b0, skip_cnt}, 32'd0);
      checkOutput("rst_out_result", out_result, 32'd0);
      checkOutput("rst_out_taken", {31'b0, out_taken}, 32'd0);

      reset_n = 1'b1;
      idleCycle();
      checkOutput("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("post_rst_out_valid", {31'b0, out_valid}, 32'd0);

      applyStimulus(1'b1, COND_AL, 1'b1, 32'hFFFF_FFFF, 4'b1000);
      checkOutput("al_out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("al_out_result", out_result, 32'hFFFF_FFFF);
      checkOutput("al_out_taken", {31'b0, out_taken}, 32'd1);
      checkOutput("al_nzcv", {28'b0, nzcv}, 32'b1000);
      checkOutput("al_taken_cnt", {16'b0, taken_cnt}, 32'd1);

      applyStimulus(1'b1, COND_AL, 1'b1, 32'h0, 4'b0100);
      checkOutput("set_z_nzcv", {28'b0, nzcv}, 32'b0100);
      applyStimulus(1'b1, COND_EQ, 1'b1, 32'h5, 4'b0001);
      checkOutput("eq1_out_result", out_result, 32'h5);
      checkOutput("eq1_out_taken", {31'b0, out_taken}, 32'd1);
      checkOutput("eq1_nzcv", {28'b0, nzcv}, 32'b0001);
      applyStimulus(1'b1, COND_EQ, 1'b1, 32'h6, 4'b1111);
      checkOutput("eq2_out_result", out_result, 32'h6);
      checkOutput("eq2_out_taken", {31'b0, out_taken}, 32'd0);
      checkOutput("eq2_nzcv", {28'b0, nzcv}, 32'b0001);
      checkOutput("eq2_skip_cnt", {16'b0, skip_cnt}, 32'd1);
      checkOutput("eq2_taken_cnt", {16'b0, taken_cnt}, 32'd3);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, COND_AL, 1'b1, 32'h100 + i, sweepNzcv[i]);
         checkOutput("sweep_set_nzcv", {28'b0, nzcv}, {28'b0, sweepNzcv[i]});
         for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b1, sweepCond[j], 1'b0, 32'h200 + 32'(i * 4 + j), 4'b0000);
            checkOutput($sformatf("sweep_taken_nzcv%b_cond%b", sweepNzcv[i], sweepCond[j]),
                        {31'b0, out_taken}, {31'b0, sweepExp[i][3-j]});
         end
      end
      checkOutput("sweep_taken_cnt", {16'b0, taken_cnt}, 32'd18);
      checkOutput("sweep_skip_cnt", {16'b0, skip_cnt}, 32'd11);

      applyStimulus(1'b1, COND_AL, 1'b1, 32'h300, 4'b1011);
      for (int j = 0; j < 12; j++) begin
         applyStimulus(1'b1, miscCond[j], 1'b0, 32'h400 + 32'(j), 4'b0000);
         checkOutput($sformatf("misc_taken_cond%b", miscCond[j]), {31'b0, out_taken}, {31'b0, miscExp[j]});
      end
      checkOutput("misc_taken_cnt", {16'b0, taken_cnt}, 32'd25);
      checkOutput("misc_skip_cnt", {16'b0, skip_cnt}, 32'd17);
      checkOutput("misc_nzcv", {28'b0, nzcv}, 32'b1011);

      idleCycle();
      checkOutput("drain_out_valid", {31'b0, out_valid}, 32'd0);

      out_ready = 1'b0;
      applyStimulus(1'b1, COND_AL, 1'b0, 32'h1, 4'b0000);
      checkOutput("bp_in_ready_1", {31'b0, in_ready}, 32'd1);
      applyStimulus(1'b1, COND_AL, 1'b0, 32'h2, 4'b0000);
      checkOutput("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
      applyStimulus(1'b1, COND_AL, 1'b0, 32'h3, 4'b0000);
      checkOutput("bp_held_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("bp_head_1", out_result, 32'h1);
      out_ready = 1'b1;
      applyStimulus(1'b1, COND_AL, 1'b0, 32'h3, 4'b0000);
      checkOutput("bp_head_2", out_result, 32'h2);
      checkOutput("bp_in_ready_reopen", {31'b0, in_ready}, 32'd1);
      applyStimulus(1'b1, COND_AL, 1'b0, 32'h3, 4'b0000);
      checkOutput("bp_head_3", out_result, 32'h3);
      checkOutput("bp_valid_3", {31'b0, out_valid}, 32'd1);
      idleCycle();
      checkOutput("bp_drained", {31'b0, out_valid}, 32'd0);

      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, COND_AL, 1'b0, 32'h10 + 32'(k), 4'b0000);
         checkOutput($sformatf("stream_result_%0d", k), out_result, 32'h10 + 32'(k));
         checkOutput($sformatf("stream_valid_%0d", k), {31'b0, out_valid}, 32'd1);
         checkOutput($sformatf("stream_in_ready_%0d", k), {31'b0, in_ready}, 32'd1);
      end
      idleCycle();
      checkOutput("stream_drained", {31'b0, out_valid}, 32'd0);

      applyStimulus(1'b1, COND_AL, 1'b1, 32'h500, 4'b1111);
      checkOutput("pre_rst_nzcv", {28'b0, nzcv}, 32'b1111);
      idleCycle();
      out_ready = 1'b0;
      applyStimulus(1'b1, COND_AL, 1'b0, 32'hAA, 4'b0000);
      applyStimulus(1'b1, COND_AL, 1'b0, 32'hBB, 4'b0000);
      checkOutput("pre_rst_full", {31'b0, in_ready}, 32'd0);
      reset_n = 1'b0;
      idleCycle();
      checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("midrst_nzcv", {28'b0, nzcv}, 32'd0);
      checkOutput("midrst_taken_cnt", {16'b0, taken_cnt}, 32'd0);
      checkOutput("midrst_skip_cnt", {16'b0, skip_cnt}, 32'd0);
      checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("midrst_out_result", out_result, 32'd0);
      reset_n   = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         idleCycle();
         checkOutput($sformatf("midrst_no_emit_%0d", k), {31'b0, out_valid}, 32'd0);
      end
      checkOutput("midrst_in_ready_back", {31'b0, in_ready}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
